// File: rtl/ex_wb_buffer.sv
// Elastic FIFO between the execute-stage result mux and the register-file write port.
// Buffered results that have not yet been written are forwarded to decode, youngest first.
module ex_wb_buffer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [ADDR_W-1:0]        ex_rd,
    input  logic [DATA_W-1:0]        ex_result,
    input  logic                     ex_we,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [ADDR_W-1:0]        wb_rd,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     wb_we,
    input  logic [ADDR_W-1:0]        fwd_rs1,
    input  logic [ADDR_W-1:0]        fwd_rs2,
    output logic                     fwd_hit1,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]     count_reg, count_next;
    logic [PW-1:0]     head_reg, head_next;
    logic [PW-1:0]     tail_reg, tail_next;
    logic [DEPTH-1:0]  vld_reg, vld_next;

    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  we_mem;

    logic push, pop;
    logic [DEPTH-1:0] match1, match2;

    // Ready looks only at the registered count, so wb_ready never reaches ex_ready.
    assign ex_ready = (count_reg < CW'(DEPTH));
    assign wb_valid = (count_reg != '0);
    assign push     = ex_valid & ex_ready;
    assign pop      = wb_valid & wb_ready;
    assign count    = count_reg;

    assign wb_rd   = wb_valid ? rd_mem[head_reg]   : '0;
    assign wb_data = wb_valid ? data_mem[head_reg] : '0;
    assign wb_we   = wb_valid ? we_mem[head_reg]   : 1'b0;

    always_comb begin
        count_next = count_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        vld_next   = vld_reg;
        if (flush) begin
            count_next = '0;
            head_next  = '0;
            tail_next  = '0;
            vld_next   = '0;
        end else begin
            if (push) begin
                tail_next          = tail_reg + PW'(1);
                vld_next[tail_reg] = 1'b1;
            end
            if (pop) begin
                head_next          = head_reg + PW'(1);
                vld_next[head_reg] = 1'b0;
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            vld_reg   <= '0;
        end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            vld_reg   <= vld_next;
        end
    end

    // Payload storage needs no reset: every read is qualified by count or a valid bit.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            rd_mem[tail_reg]   <= ex_rd;
            data_mem[tail_reg] <= ex_result;
            we_mem[tail_reg]   <= ex_we & (ex_rd != '0);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match1[gi] = vld_reg[gi] & we_mem[gi] & (rd_mem[gi] == fwd_rs1) & (fwd_rs1 != '0);
            assign match2[gi] = vld_reg[gi] & we_mem[gi] & (rd_mem[gi] == fwd_rs2) & (fwd_rs2 != '0);
        end
    endgenerate

    // Walk from oldest (head) to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PW'(k);
            if (match1[idx]) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_mem[idx];
            end
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PW'(k);
            if (match2[idx]) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_mem[idx];
            end
        end
    end

endmodule
